pga_gain_ctrl: RTL and testbench

//  Automatic gain control for the receiver front end; sits directly upstream of the PGA SPI

---
 rtl/pga_gain_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pga_gain_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pga_gain_ctrl.sv
// pga_gain_ctrl
//   Receiver front-end AGC. It measures the peak |sample| of the ADC stream over a
//   fixed window and moves the PGA gain index one step per window. Each new code goes
//   to the PGA SPI interface over a set/ready handshake. While the analog path
//   settles, the block discards a fixed number of valid samples.
//
// Ports
//   sck             in   system clock (shared with the PGA SPI interface)
//   rst_n           in   asynchronous reset, active low
//   sample_i        in   signed ADC sample
//   sample_valid_i  in   sample qualifier, single-cycle strobes
//   enable_i        in   1 = AGC free-running, 0 = hold gain (in-flight update completes)
//   ready_i         in   PGA interface idle
//   code_o          out  PGA code byte {CODE_PREFIX, target gain}
//   set_o           out  single-cycle request strobe to the PGA interface
//   gain_o          out  gain index currently applied
//   busy_o          out  update in flight or analog path settling
//   overload_o      out  single-cycle pulse at window end when peak reached full scale
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ISSUE      | present target code, strobe set_o once ready_i is high
// WAIT_ACK   | wait for ready_i to drop (gives up after 4 cycles)
// WAIT_DONE  | wait for ready_i to return, then apply target as gain
// SETTLE     | discard SETTLE valid samples
// MEASURE    | track peak |x| over WINDOW valid samples
// DECIDE     | compare peak with thresholds, choose next step

module pga_gain_ctrl #(
  parameter int         ADC_W       = 12,
  parameter int         WINDOW      = 256,
  parameter int         HI_THRESH   = 1536,
  parameter int         LO_THRESH   = 384,
  parameter int         MAX_GAIN    = 15,
  parameter int         INIT_GAIN   = 4,
  parameter int         SETTLE      = 32,
  parameter logic [3:0] CODE_PREFIX = 4'h8
) (
  input  logic                    sck,
  input  logic                    rst_n,
  input  logic signed [ADC_W-1:0] sample_i,
  input  logic                    sample_valid_i,
  input  logic                    enable_i,
  input  logic                    ready_i,
  output logic [7:0]              code_o,
  output logic                    set_o,
  output logic [3:0]              gain_o,
  output logic                    busy_o,
  output logic                    overload_o
);

  localparam int PW = ADC_W - 1;
  localparam int WW = $clog2(WINDOW + 1);
  localparam int SW = $clog2(SETTLE + 1);

  localparam logic [PW-1:0]    FULL_SCALE = {PW{1'b1}};
  localparam logic [ADC_W-1:0] MOST_NEG   = {1'b1, {PW{1'b0}}};
  localparam logic [PW-1:0]    HI_LVL     = PW'(HI_THRESH);
  localparam logic [PW-1:0]    LO_LVL     = PW'(LO_THRESH);
  localparam logic [3:0]       GAIN_MAX   = 4'(MAX_GAIN);
  localparam logic [3:0]       GAIN_INIT  = 4'(INIT_GAIN);
  localparam logic [WW-1:0]    WIN_LOAD   = WW'(WINDOW - 1);
  localparam logic [SW-1:0]    SET_LOAD   = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DECIDE
  } state_t;

  state_t          state;
  logic [3:0]      target;
  logic [3:0]      gain;
  logic [PW-1:0]   peak;
  logic [WW-1:0]   win_cnt;
  logic [SW-1:0]   settle_cnt;
  logic [1:0]      ack_cnt;

  logic [ADC_W-1:0] samp;
  logic [ADC_W-1:0] samp_neg;
  logic [PW-1:0]    mag;

  // The most negative code has no positive twin in ADC_W bits, so it is pinned to full scale.
  always_comb begin
    samp     = sample_i;
    samp_neg = ~samp + 1'b1;
    if (!samp[ADC_W-1])
      mag = samp[PW-1:0];
    else if (samp == MOST_NEG)
      mag = FULL_SCALE;
    else
      mag = samp_neg[PW-1:0];
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ISSUE;
      target     <= GAIN_INIT;
      gain       <= GAIN_INIT;
      set_o      <= 1'b0;
      overload_o <= 1'b0;
      peak       <= '0;
      win_cnt    <= '0;
      settle_cnt <= '0;
      ack_cnt    <= '0;
    end else begin
      set_o      <= 1'b0;
      overload_o <= 1'b0;
      case (state)
        ST_ISSUE: begin
          if (ready_i) begin
            set_o   <= 1'b1;
            ack_cnt <= 2'd3;
            state   <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // Some PGA interfaces finish too fast to ever show ready low; time out.
          if (!ready_i || ack_cnt == 2'd0)
            state <= ST_WAIT_DONE;
          else
            ack_cnt <= ack_cnt - 2'd1;
        end
        ST_WAIT_DONE: begin
          if (ready_i) begin
            gain       <= target;
            settle_cnt <= SET_LOAD;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (sample_valid_i) begin
            if (settle_cnt == '0) begin
              peak    <= '0;
              win_cnt <= WIN_LOAD;
              state   <= ST_MEASURE;
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end
        end
        ST_MEASURE: begin
          if (sample_valid_i) begin
            if (mag > peak)
              peak <= mag;
            if (win_cnt == '0)
              state <= ST_DECIDE;
            else
              win_cnt <= win_cnt - 1'b1;
          end
        end
        ST_DECIDE: begin
          overload_o <= (peak == FULL_SCALE);
          peak       <= '0;
          win_cnt    <= WIN_LOAD;
          if (enable_i && peak >= HI_LVL && gain != 4'd0) begin
            target <= gain - 4'd1;
            state  <= ST_ISSUE;
          end else if (enable_i && peak < LO_LVL && gain < GAIN_MAX) begin
            target <= gain + 4'd1;
            state  <= ST_ISSUE;
          end else begin
            state <= ST_MEASURE;
          end
        end
        default: state <= ST_ISSUE;
      endcase
    end
  end

  assign code_o = {CODE_PREFIX, target};
  assign gain_o = gain;
  assign busy_o = (state != ST_MEASURE) && (state != ST_DECIDE);

endmodule

// File: tb/tb_pga_gain_ctrl.sv
// Directed bench for pga_gain_ctrl. A small PGA-interface model answers set_o by
// dropping ready_i for a programmable number of cycles.

module tb_pga_gain_ctrl;

  logic               sck = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [11:0] sample_i = '0;
  logic               sample_valid_i = 1'b0;
  logic               enable_i = 1'b1;
  logic               ready_i = 1'b1;
  logic [7:0]         code_o;
  logic               set_o;
  logic [3:0]         gain_o;
  logic               busy_o;
  logic               overload_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int set_cnt = 0;
  int set_cyc = 0;
  int ovl_cnt = 0;
  int viol = 0;
  int last_cyc = 0;
  logic [7:0] last_code = '0;
  bit prev_set = 1'b0;
  bit auto_pga = 1'b1;
  int pga_hold = 0;
  int pga_len = 3;

  pga_gain_ctrl dut (
    .sck            (sck),
    .rst_n          (rst_n),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .enable_i       (enable_i),
    .ready_i        (ready_i),
    .code_o         (code_o),
    .set_o          (set_o),
    .gain_o         (gain_o),
    .busy_o         (busy_o),
    .overload_o     (overload_o)
  );

  always #5 sck = ~sck;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; observe outputs 1 time unit after the edge, then update the PGA model.
  task automatic tick();
    @(posedge sck);
    #1;
    cyc++;
    if (set_o) begin
      set_cnt++;
      last_code = code_o;
      set_cyc = cyc;
      if (!ready_i) viol++;
      if (prev_set) viol++;
    end
    prev_set = set_o;
    if (overload_o) ovl_cnt++;
    if (auto_pga) begin
      if (set_o) pga_hold = pga_len;
      else if (pga_hold > 0) pga_hold--;
      ready_i = (pga_hold == 0);
    end
  endtask

  // 256 valid samples alternating +amp/-amp; a nonzero 'special' replaces sample 100.
  task automatic window(input int amp, input int special);
    for (int i = 0; i < 256; i++) begin
      if (special != 0 && i == 100) sample_i = 12'(special);
      else if (i % 2 == 1)          sample_i = 12'(-amp);
      else                          sample_i = 12'(amp);
      sample_valid_i = 1'b1;
      tick();
    end
    last_cyc = cyc;
    sample_valid_i = 1'b0;
    sample_i = '0;
    repeat (6) tick();
  endtask

  // Feed samples until the block is back in MEASURE; returns how many were fed.
  task automatic wait_measure(output int n);
    n = 0;
    while (busy_o && n < 400) begin
      sample_i = 12'sd5;
      sample_valid_i = 1'b1;
      tick();
      n++;
    end
    sample_valid_i = 1'b0;
    chk("settle_bound", busy_o, 0);
  endtask

  initial begin
    int n, s0, o0;

    // Reset values
    #12;
    chk("rst_set", set_o, 0);
    chk("rst_ovl", overload_o, 0);
    chk("rst_busy", busy_o, 1);
    chk("rst_gain", gain_o, 4);
    chk("rst_code", code_o, 'h84);
    @(posedge sck); #1;
    rst_n = 1'b1;

    // Initial gain issue
    s0 = set_cnt;
    repeat (8) tick();
    chk("init_set_cnt", set_cnt - s0, 1);
    chk("init_code", last_code, 'h84);
    chk("init_gain", gain_o, 4);
    chk("init_busy", busy_o, 1);
    wait_measure(n);
    chk("settle_samples", n, 32);

    // Low signal ramps the gain up to the clamp
    s0 = set_cnt;
    window(200, 0);
    chk("up_set", set_cnt - s0, 1);
    chk("up_code", last_code, 'h85);
    chk("up_latency", set_cyc - last_cyc, 2);
    wait_measure(n);
    chk("up_gain", gain_o, 5);
    for (int g = 6; g <= 15; g++) begin
      window(200, 0);
      wait_measure(n);
      chk("ramp_gain", gain_o, g);
    end
    s0 = set_cnt;
    window(200, 0);
    wait_measure(n);
    chk("max_no_set", set_cnt - s0, 0);
    chk("max_code", code_o, 'h8F);
    chk("max_gain", gain_o, 15);

    // Full-scale negative sample: overload and step down
    s0 = set_cnt; o0 = ovl_cnt;
    window(200, -2048);
    chk("ovl_pulse", ovl_cnt - o0, 1);
    chk("ovl_set", set_cnt - s0, 1);
    chk("ovl_code", last_code, 'h8E);
    wait_measure(n);
    chk("ovl_gain", gain_o, 14);

    // Threshold boundaries
    s0 = set_cnt;
    window(384, 0);
    wait_measure(n);
    chk("lo_edge_no_set", set_cnt - s0, 0);
    chk("lo_edge_gain", gain_o, 14);
    s0 = set_cnt; o0 = ovl_cnt;
    window(1535, 0);
    wait_measure(n);
    chk("hi_edge_no_set", set_cnt - s0, 0);
    chk("hi_edge_no_ovl", ovl_cnt - o0, 0);
    window(1536, 0);
    chk("hi_down_code", last_code, 'h8D);
    wait_measure(n);
    chk("hi_down_gain", gain_o, 13);
    window(383, 0);
    wait_measure(n);
    chk("lo_up_gain", gain_o, 14);

    // Step down to the lower clamp
    s0 = set_cnt;
    for (int k = 0; k < 14; k++) begin
      window(1600, 0);
      wait_measure(n);
    end
    chk("down_sets", set_cnt - s0, 14);
    chk("down_gain", gain_o, 0);
    s0 = set_cnt; o0 = ovl_cnt;
    window(200, -2048);
    wait_measure(n);
    chk("min_ovl_pulse", ovl_cnt - o0, 1);
    chk("min_no_set", set_cnt - s0, 0);
    chk("min_code", code_o, 'h80);

    // ready_i held low in ISSUE, then never dropping after the strobe
    auto_pga = 1'b0;
    ready_i = 1'b0;
    s0 = set_cnt;
    window(100, 0);
    repeat (50) tick();
    chk("hold_no_set", set_cnt - s0, 0);
    chk("hold_busy", busy_o, 1);
    ready_i = 1'b1;
    tick();
    chk("release_set", set_cnt - s0, 1);
    chk("release_code", last_code, 'h81);
    repeat (4) tick();
    chk("ack_timeout_early", gain_o, 0);
    tick();
    chk("ack_timeout_gain", gain_o, 1);
    auto_pga = 1'b1;
    wait_measure(n);

    // Disabled: gain frozen
    enable_i = 1'b0;
    s0 = set_cnt;
    window(100, 0);
    wait_measure(n);
    chk("dis_no_set", set_cnt - s0, 0);
    chk("dis_gain", gain_o, 1);
    chk("dis_busy", busy_o, 0);

    // Reset while waiting for ready_i to return
    enable_i = 1'b1;
    pga_len = 20;
    window(100, 0);
    chk("pre_rst_code", last_code, 'h82);
    chk("pre_rst_gain", gain_o, 1);
    chk("pre_rst_busy", busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_set", set_o, 0);
    chk("mid_rst_ovl", overload_o, 0);
    chk("mid_rst_busy", busy_o, 1);
    chk("mid_rst_gain", gain_o, 4);
    chk("mid_rst_code", code_o, 'h84);
    pga_hold = 0;
    pga_len = 3;
    ready_i = 1'b1;
    prev_set = 1'b0;
    @(posedge sck); #1;
    rst_n = 1'b1;
    s0 = set_cnt;
    repeat (8) tick();
    chk("reissue_set", set_cnt - s0, 1);
    chk("reissue_code", last_code, 'h84);

    chk("set_rules", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
